serial_frame_deserializer: RTL and testbench

- Downstream consumer of the 4-bit serial shift-register stage. Takes its single-bit serial stream (MSB-first) and hunts for a sync pattern.
- After sync, assembles a DATA_W-bit word and checks a trailing even-parity bit.
- Presents good words through a one-entry valid/ready output buffer, with overrun, parity-error and frame-count status.

---
 rtl/serial_frame_deserializer.sv | 141 ++++++++++++++
 tb/tb_serial_frame_deserializer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_deserializer.sv
// -----------------------------------------------------------------------------
// serial_frame_deserializer
//
// Consumes an MSB-first serial bit stream, hunts for a sync pattern, then
// assembles a DATA_W-bit word followed by an even-parity bit. Good words are
// presented through a one-entry valid/ready output buffer.
//
// Ports:
//   clk          - single clock, all state updates on the rising edge
//   reset_n      - synchronous active-low reset
//   serial_in    - serial data bit
//   bit_en       - sample strobe; serial_in consumed only when high
//   data_out     - word held in the output buffer
//   data_valid   - buffer holds an unconsumed word
//   data_ready   - consumer accepts data_out when data_valid && data_ready
//   parity_err   - one-cycle pulse after a frame with bad parity
//   overrun      - sticky flag, set when a good word is dropped (buffer full)
//   locked       - high while receiving payload or parity bit
//   frame_count  - number of good words written into the buffer (mod 256)
// -----------------------------------------------------------------------------
module serial_frame_deserializer #(
    parameter int                DATA_W       = 8,
    parameter int                SYNC_W       = 4,
    parameter logic [SYNC_W-1:0] SYNC_PATTERN = 4'b1011
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              serial_in,
    input  logic              bit_en,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    input  logic              data_ready,
    output logic              parity_err,
    output logic              overrun,
    output logic              locked,
    output logic [7:0]        frame_count
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        RECV   = 2'd1,
        PARITY = 2'd2
    } state_t;

    state_t              state_r;
    logic [SYNC_W-1:0]   window_r;
    logic [SYNC_W-1:0]   window_shift_s;
    logic [CNT_W-1:0]    cnt_r;
    logic [DATA_W-1:0]   word_r;
    logic [DATA_W-1:0]   data_out_r;
    logic                data_valid_r;
    logic                parity_err_r;
    logic                overrun_r;
    logic                locked_r;
    logic [7:0]          frame_count_r;

    // True when the payload plus its trailing bit carries even parity.
    function automatic logic even_parity_ok(input logic [DATA_W-1:0] word,
                                            input logic              par_bit);
        return ((^word) ^ par_bit) == 1'b0;
    endfunction

    // Candidate sync window including the bit currently on serial_in.
    assign window_shift_s = {window_r[SYNC_W-2:0], serial_in};

    // Frame FSM, sync window, payload shifter and output buffer.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r       <= HUNT;
            window_r      <= '0;
            cnt_r         <= '0;
            word_r        <= '0;
            data_out_r    <= '0;
            data_valid_r  <= 1'b0;
            parity_err_r  <= 1'b0;
            overrun_r     <= 1'b0;
            locked_r      <= 1'b0;
            frame_count_r <= 8'd0;
        end else begin
            parity_err_r <= 1'b0;

            // Consumer take: the buffer empties unless refilled on this same
            // edge by the parity branch below (later assignment wins).
            if (data_valid_r && data_ready) begin
                data_valid_r <= 1'b0;
            end

            if (bit_en) begin
                case (state_r)
                    HUNT: begin
                        if (window_shift_s == SYNC_PATTERN) begin
                            state_r  <= RECV;
                            window_r <= '0;
                            cnt_r    <= '0;
                            locked_r <= 1'b1;
                        end else begin
                            window_r <= window_shift_s;
                        end
                    end
                    RECV: begin
                        word_r <= {word_r[DATA_W-2:0], serial_in};
                        cnt_r  <= cnt_r + CNT_W'(1);
                        if (cnt_r == CNT_W'(DATA_W - 1)) begin
                            state_r <= PARITY;
                        end
                    end
                    PARITY: begin
                        state_r  <= HUNT;
                        window_r <= '0;
                        locked_r <= 1'b0;
                        if (!even_parity_ok(word_r, serial_in)) begin
                            parity_err_r <= 1'b1;
                        end else if (!data_valid_r || data_ready) begin
                            data_out_r    <= word_r;
                            data_valid_r  <= 1'b1;
                            frame_count_r <= frame_count_r + 8'd1;
                        end else begin
                            overrun_r <= 1'b1;
                        end
                    end
                    default: begin
                        state_r  <= HUNT;
                        window_r <= '0;
                        cnt_r    <= '0;
                        locked_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign data_out    = data_out_r;
    assign data_valid  = data_valid_r;
    assign parity_err  = parity_err_r;
    assign overrun     = overrun_r;
    assign locked      = locked_r;
    assign frame_count = frame_count_r;

endmodule

// File: tb/tb_serial_frame_deserializer.sv
// -----------------------------------------------------------------------------
// tb_serial_frame_deserializer
//
// Directed self-checking bench for serial_frame_deserializer. Inputs change on
// the falling edge; outputs are sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_serial_frame_deserializer;

    logic       clk;
    logic       reset_n;
    logic       serial_in;
    logic       bit_en;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ready;
    logic       parity_err;
    logic       overrun;
    logic       locked;
    logic [7:0] frame_count;

    int n_checks = 0;
    int n_fail   = 0;

    serial_frame_deserializer #(
        .DATA_W      (8),
        .SYNC_W      (4),
        .SYNC_PATTERN(4'b1011)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .serial_in  (serial_in),
        .bit_en     (bit_en),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .parity_err (parity_err),
        .overrun    (overrun),
        .locked     (locked),
        .frame_count(frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One strobed bit, then settle just past the rising edge.
    task automatic send_bit(input logic b);
        @(negedge clk);
        serial_in = b;
        bit_en    = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // One un-strobed cycle with a junk serial value that must be ignored.
    task automatic idle(input logic junk);
        @(negedge clk);
        serial_in = junk;
        bit_en    = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic send_sync();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset_n   = 1'b0;
        bit_en    = 1'b0;
        serial_in = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n    = 1'b0;
        serial_in  = 1'b0;
        bit_en     = 1'b0;
        data_ready = 1'b1;

        // ---- Reset state ----
        apply_reset();
        chk("rst_data_out",    data_out, 8'h00);
        chk("rst_data_valid",  8'(data_valid), 8'h00);
        chk("rst_parity_err",  8'(parity_err), 8'h00);
        chk("rst_overrun",     8'(overrun), 8'h00);
        chk("rst_locked",      8'(locked), 8'h00);
        chk("rst_frame_count", frame_count, 8'h00);

        // ---- Good frame 0xA5, parity 0 ----
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        chk("a5_prelock", 8'(locked), 8'h00);
        send_bit(1'b1);
        chk("a5_lock", 8'(locked), 8'h01);
        send_byte(8'hA5);
        chk("a5_lock_data",  8'(locked), 8'h01);
        chk("a5_no_valid",   8'(data_valid), 8'h00);
        send_bit(1'b0);
        chk("a5_valid",      8'(data_valid), 8'h01);
        chk("a5_data",       data_out, 8'hA5);
        chk("a5_count",      frame_count, 8'h01);
        chk("a5_unlock",     8'(locked), 8'h00);
        idle(1'b1);
        chk("a5_valid_drop", 8'(data_valid), 8'h00);
        chk("a5_data_hold",  data_out, 8'hA5);

        // ---- Bad parity frame 0x3C with parity 1 ----
        send_sync();
        send_byte(8'h3C);
        send_bit(1'b1);
        chk("3c_perr",       8'(parity_err), 8'h01);
        chk("3c_no_valid",   8'(data_valid), 8'h00);
        chk("3c_count",      frame_count, 8'h01);
        chk("3c_data_keep",  data_out, 8'hA5);
        idle(1'b0);
        chk("3c_perr_pulse", 8'(parity_err), 8'h00);

        // ---- Overrun: 0x5A then 0xC3 with data_ready low ----
        apply_reset();
        data_ready = 1'b0;
        send_sync(); send_byte(8'h5A); send_bit(1'b0);
        chk("5a_valid", 8'(data_valid), 8'h01);
        chk("5a_data",  data_out, 8'h5A);
        send_sync(); send_byte(8'hC3); send_bit(1'b0);
        chk("c3_data_hold", data_out, 8'h5A);
        chk("c3_valid",     8'(data_valid), 8'h01);
        chk("c3_overrun",   8'(overrun), 8'h01);
        chk("c3_count",     frame_count, 8'h01);
        @(negedge clk);
        data_ready = 1'b1;
        bit_en     = 1'b0;
        @(posedge clk);
        #1;
        chk("ovr_valid_drop", 8'(data_valid), 8'h00);
        chk("ovr_data_hold",  data_out, 8'h5A);
        chk("ovr_sticky",     8'(overrun), 8'h01);

        // ---- False-sync prefix 1,0,1,0,1,1 then 0xFF ----
        apply_reset();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        send_bit(1'b0); send_bit(1'b1);
        chk("fs_not_locked", 8'(locked), 8'h00);
        send_bit(1'b1);
        chk("fs_locked", 8'(locked), 8'h01);
        send_byte(8'hFF); send_bit(1'b0);
        chk("ff_valid", 8'(data_valid), 8'h01);
        chk("ff_data",  data_out, 8'hFF);
        chk("ff_count", frame_count, 8'h01);

        // ---- Sparse strobe, 0x81 ----
        apply_reset();
        send_sync();
        for (int i = 7; i >= 0; i--) begin
            logic [7:0] v;
            v = 8'h81;
            send_bit(v[i]);
            idle(~v[i]);
            idle(~v[i]);
        end
        chk("81_locked_gap", 8'(locked), 8'h01);
        chk("81_no_valid",   8'(data_valid), 8'h00);
        send_bit(1'b0);
        chk("81_valid", 8'(data_valid), 8'h01);
        chk("81_data",  data_out, 8'h81);
        chk("81_count", frame_count, 8'h01);
        chk("81_perr",  8'(parity_err), 8'h00);

        // ---- Reset mid-frame, then 0x0F ----
        apply_reset();
        send_sync();
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
        @(negedge clk);
        reset_n   = 1'b0;
        bit_en    = 1'b1;
        serial_in = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_locked", 8'(locked), 8'h00);
        chk("mid_rst_count",  frame_count, 8'h00);
        @(negedge clk);
        reset_n = 1'b1;
        send_sync(); send_byte(8'h0F); send_bit(1'b0);
        chk("0f_valid",   8'(data_valid), 8'h01);
        chk("0f_data",    data_out, 8'h0F);
        chk("0f_count",   frame_count, 8'h01);
        chk("0f_overrun", 8'(overrun), 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
